// File: rtl/load_unit.sv
// Load unit: fetches one or two aligned memory words for a byte-addressed load,
// then aligns and sign/zero-extends the requested field.
module load_unit #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_sel,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_SIZE-1:0]  mem_rsp_data,
  output logic                  ld_valid,
  output logic [WORD_SIZE-1:0]  ld_data,
  output logic                  ld_split
);

  localparam int BYTES = WORD_SIZE / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ0  = 3'd1;
  localparam logic [2:0] WAIT0 = 3'd2;
  localparam logic [2:0] REQ1  = 3'd3;
  localparam logic [2:0] WAIT1 = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state_r, state_n;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            sel_r;
  logic [WORD_SIZE-1:0]  lo_r, hi_r, lo_s, hi_s;
  logic [WORD_SIZE-1:0]  word_s, result_s;
  logic [OFF_W+2:0]      shamt_s;
  logic [4:0]            end_s;
  logic                  split_s, accept_s;
  logic                  mem_rd_valid_r, ld_valid_r, ld_split_r;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_r;
  logic [WORD_SIZE-1:0]  ld_data_r;

  function automatic logic [3:0] acc_size(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd3: acc_size = 4'd1;
      3'd1, 3'd4: acc_size = 4'd2;
      3'd2:       acc_size = 4'd4;
      3'd5:       acc_size = (WORD_SIZE == 64) ? 4'd8 : 4'd1;
      3'd6:       acc_size = (WORD_SIZE == 64) ? 4'd4 : 4'd1;
      default:    acc_size = 4'd1;
    endcase
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel);
    if (sel <= 3'd4)
      sel_legal = 1'b1;
    else if (sel == 3'd7)
      sel_legal = 1'b0;
    else
      sel_legal = (WORD_SIZE == 64);
  endfunction

  function automatic logic [WORD_SIZE-1:0] extend(input logic [WORD_SIZE-1:0] w,
                                                  input logic [2:0] sel);
    case (sel)
      3'd0:    extend = WORD_SIZE'($signed(w[7:0]));
      3'd1:    extend = WORD_SIZE'($signed(w[15:0]));
      3'd2:    extend = (WORD_SIZE == 64) ? WORD_SIZE'($signed(w[31:0])) : w;
      3'd3:    extend = WORD_SIZE'(w[7:0]);
      3'd4:    extend = WORD_SIZE'(w[15:0]);
      3'd5:    extend = w;
      3'd6:    extend = WORD_SIZE'(w[31:0]);
      default: extend = {WORD_SIZE{1'b0}};
    endcase
  endfunction

  // Datapath: incoming words, split decision and aligned/extended result
  always_comb begin
    accept_s = (state_r == IDLE) && req_valid;
    if (state_r == WAIT0 && mem_rsp_valid) lo_s = mem_rsp_data;
    else                                   lo_s = lo_r;
    if (state_r == WAIT1 && mem_rsp_valid) hi_s = mem_rsp_data;
    else                                   hi_s = hi_r;
    end_s    = 5'(addr_r[OFF_W-1:0]) + 5'(acc_size(sel_r));
    split_s  = (end_s > 5'(BYTES));
    shamt_s  = {addr_r[OFF_W-1:0], 3'b000};
    word_s   = WORD_SIZE'({hi_s, lo_s} >> shamt_s);
    if (sel_legal(sel_r)) result_s = extend(word_s, sel_r);
    else                  result_s = {WORD_SIZE{1'b0}};
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (req_valid) state_n = REQ0; else state_n = IDLE;
      REQ0:    if (mem_rd_ready) state_n = WAIT0; else state_n = REQ0;
      WAIT0: begin
        if (mem_rsp_valid) state_n = split_s ? REQ1 : DONE;
        else               state_n = WAIT0;
      end
      REQ1:    if (mem_rd_ready) state_n = WAIT1; else state_n = REQ1;
      WAIT1:   if (mem_rsp_valid) state_n = DONE; else state_n = WAIT1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, captured request and read words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      sel_r   <= 3'd0;
      lo_r    <= {WORD_SIZE{1'b0}};
      hi_r    <= {WORD_SIZE{1'b0}};
    end else begin
      state_r <= state_n;
      lo_r    <= lo_s;
      if (accept_s) begin
        addr_r <= req_addr;
        sel_r  <= req_sel;
        hi_r   <= {WORD_SIZE{1'b0}};
      end else begin
        hi_r <= hi_s;
      end
    end
  end

  // Registered outputs, loaded from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_valid_r <= 1'b0;
      mem_rd_addr_r  <= {ADDR_WIDTH{1'b0}};
      ld_valid_r     <= 1'b0;
      ld_data_r      <= {WORD_SIZE{1'b0}};
      ld_split_r     <= 1'b0;
    end else begin
      mem_rd_valid_r <= (state_n == REQ0) || (state_n == REQ1);
      ld_valid_r     <= (state_n == DONE);
      if (accept_s)
        mem_rd_addr_r <= req_addr & ~OFF_MASK;
      else if (state_r == WAIT0 && state_n == REQ1)
        mem_rd_addr_r <= mem_rd_addr_r + ADDR_WIDTH'(BYTES);
      if (state_n == DONE) begin
        ld_data_r  <= result_s;
        ld_split_r <= (state_r == WAIT1);
      end
    end
  end

  // Ready must read low for the whole reset pulse, even though the FSM already sits in IDLE
  assign req_ready    = (state_r == IDLE) && !rst;
  assign mem_rd_valid = mem_rd_valid_r;
  assign mem_rd_addr  = mem_rd_addr_r;
  assign ld_valid     = ld_valid_r;
  assign ld_data      = ld_data_r;
  assign ld_split     = ld_split_r;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a 32-bit and a 64-bit instance share request and
// memory inputs; a task plays the memory and checks each load against hand values.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid32, req_valid64;
  logic [31:0] req_addr;
  logic [2:0]  req_sel;
  logic        mem_rd_ready;
  logic        mem_rsp_valid32, mem_rsp_valid64;
  logic [63:0] mem_rsp_data;

  logic        req_ready32, mem_rd_valid32, ld_valid32, ld_split32;
  logic [31:0] mem_rd_addr32, ld_data32;
  logic        req_ready64, mem_rd_valid64, ld_valid64, ld_split64;
  logic [31:0] mem_rd_addr64;
  logic [63:0] ld_data64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_unit #(.WORD_SIZE(32), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32),
    .req_addr(req_addr), .req_sel(req_sel), .mem_rd_valid(mem_rd_valid32),
    .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr32),
    .mem_rsp_valid(mem_rsp_valid32), .mem_rsp_data(mem_rsp_data[31:0]),
    .ld_valid(ld_valid32), .ld_data(ld_data32), .ld_split(ld_split32)
  );

  load_unit #(.WORD_SIZE(64), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid64), .req_ready(req_ready64),
    .req_addr(req_addr), .req_sel(req_sel), .mem_rd_valid(mem_rd_valid64),
    .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr64),
    .mem_rsp_valid(mem_rsp_valid64), .mem_rsp_data(mem_rsp_data),
    .ld_valid(ld_valid64), .ld_data(ld_data64), .ld_split(ld_split64)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one load to the chosen instance, serve its reads, check result and timing.
  task automatic do_load(input bit w64, input string tag, input logic [31:0] addr,
                         input logic [2:0] sel, input logic [63:0] lo, input logic [63:0] hi,
                         input logic [63:0] exp_data, input bit exp_split,
                         input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int cyc;
    int nrd;
    bit pend;
    bit got;
    logic [31:0] a0, a1;
    @(negedge clk);
    req_addr    = addr;
    req_sel     = sel;
    req_valid32 = !w64;
    req_valid64 = w64;
    check_val({tag, "/ready"}, w64 ? req_ready64 : req_ready32, 64'd1);
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
    cyc = 1; nrd = 0; pend = 1'b0; got = 1'b0; a0 = 32'd0; a1 = 32'd0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      mem_rsp_valid32 = pend && !w64;
      mem_rsp_valid64 = pend && w64;
      mem_rsp_data    = (nrd == 2) ? hi : lo;
      pend = 1'b0;
      if (w64 ? ld_valid64 : ld_valid32) begin
        got = 1'b1;
        check_val({tag, "/data"}, w64 ? ld_data64 : {32'd0, ld_data32}, exp_data);
        check_val({tag, "/split"}, w64 ? ld_split64 : ld_split32, {63'd0, exp_split});
        check_val({tag, "/latency"}, 64'(cyc), exp_split ? 64'd6 : 64'd4);
        check_val({tag, "/reads"}, 64'(nrd), exp_split ? 64'd2 : 64'd1);
        check_val({tag, "/addr0"}, {32'd0, a0}, {32'd0, exp_a0});
        if (exp_split) check_val({tag, "/addr1"}, {32'd0, a1}, {32'd0, exp_a1});
        check_val({tag, "/busy"}, w64 ? req_ready64 : req_ready32, 64'd0);
      end else if (w64 ? mem_rd_valid64 : mem_rd_valid32) begin
        if (nrd == 0) a0 = w64 ? mem_rd_addr64 : mem_rd_addr32;
        else          a1 = w64 ? mem_rd_addr64 : mem_rd_addr32;
        nrd++;
        pend = 1'b1;
      end
    end
    if (!got) check_val({tag, "/timeout"}, 64'd0, 64'd1);
    mem_rsp_valid32 = 1'b0;
    mem_rsp_valid64 = 1'b0;
    @(negedge clk);
    check_val({tag, "/pulse"}, w64 ? ld_valid64 : ld_valid32, 64'd0);
    check_val({tag, "/hold"}, w64 ? ld_data64 : {32'd0, ld_data32}, exp_data);
    check_val({tag, "/idle"}, w64 ? req_ready64 : req_ready32, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid32 = 1'b0; req_valid64 = 1'b0; req_addr = 32'd0; req_sel = 3'd0;
    mem_rd_ready = 1'b1; mem_rsp_valid32 = 1'b0; mem_rsp_valid64 = 1'b0; mem_rsp_data = 64'd0;
    repeat (3) @(negedge clk);
    check_val("rst/ready", req_ready32, 64'd0);
    check_val("rst/rd_valid", mem_rd_valid32, 64'd0);
    check_val("rst/ld_valid", ld_valid32, 64'd0);
    rst = 1'b0;
    #1;
    check_val("rst/ready_after", req_ready32, 64'd1);

    do_load(1'b0, "lw",      32'h100, 3'd2, 64'h8000_00F0, 64'd0, 64'h8000_00F0, 1'b0, 32'h100, 32'd0);
    do_load(1'b0, "lb",      32'h103, 3'd0, 64'h80FF_0000, 64'd0, 64'hFFFF_FF80, 1'b0, 32'h100, 32'd0);
    do_load(1'b0, "lbu",     32'h103, 3'd3, 64'h80FF_0000, 64'd0, 64'h0000_0080, 1'b0, 32'h100, 32'd0);
    do_load(1'b0, "lh_split",32'h107, 3'd1, 64'hAB00_0000, 64'h0000_00CD, 64'hFFFF_CDAB, 1'b1, 32'h104, 32'h108);
    do_load(1'b0, "lw_wrap", 32'hFFFF_FFFE, 3'd2, 64'h1234_5678, 64'h9ABC_DEF0, 64'hDEF0_1234, 1'b1, 32'hFFFF_FFFC, 32'h0);
    do_load(1'b0, "lhu",     32'h102, 3'd4, 64'h8001_0000, 64'd0, 64'h0000_8001, 1'b0, 32'h100, 32'd0);
    do_load(1'b0, "lh_pos",  32'h103, 3'd1, 64'h1200_0000, 64'h0000_0034, 64'h0000_3412, 1'b1, 32'h100, 32'h104);
    do_load(1'b0, "lb_pos",  32'h200, 3'd0, 64'h0000_007F, 64'd0, 64'h0000_007F, 1'b0, 32'h200, 32'd0);
    do_load(1'b0, "ill7",    32'h101, 3'd7, 64'hFFFF_FFFF, 64'd0, 64'h0, 1'b0, 32'h100, 32'd0);
    do_load(1'b0, "ill5",    32'h103, 3'd5, 64'hFFFF_FFFF, 64'd0, 64'h0, 1'b0, 32'h100, 32'd0);

    do_load(1'b1, "uw64",    32'h0C, 3'd6, 64'h8000_0001_0000_0000, 64'd0, 64'h0000_0000_8000_0001, 1'b0, 32'h08, 32'd0);
    do_load(1'b1, "w64",     32'h0C, 3'd2, 64'h8000_0001_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0, 32'h08, 32'd0);
    do_load(1'b1, "dw_split",32'h0E, 3'd5, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00,
            64'hBBCC_DDEE_FF00_1122, 1'b1, 32'h08, 32'h10);
    do_load(1'b1, "ill64",   32'h09, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0, 1'b0, 32'h08, 32'd0);

    // Stalled first read, then reset while waiting on the second response.
    mem_rd_ready = 1'b0;
    @(negedge clk);
    req_addr = 32'h107; req_sel = 3'd1; req_valid32 = 1'b1;
    @(posedge clk);
    #1 req_valid32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall/valid", mem_rd_valid32, 64'd1);
      check_val("stall/addr", {32'd0, mem_rd_addr32}, 64'h104);
    end
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rsp_valid32 = 1'b1; mem_rsp_data = 64'hAB00_0000;
    @(negedge clk);
    mem_rsp_valid32 = 1'b0;
    check_val("stall/rd1_valid", mem_rd_valid32, 64'd1);
    check_val("stall/rd1_addr", {32'd0, mem_rd_addr32}, 64'h108);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst/ready", req_ready32, 64'd0);
    check_val("midrst/rd_valid", mem_rd_valid32, 64'd0);
    check_val("midrst/rd_addr", {32'd0, mem_rd_addr32}, 64'd0);
    check_val("midrst/ld_valid", ld_valid32, 64'd0);
    check_val("midrst/ld_data", {32'd0, ld_data32}, 64'd0);
    check_val("midrst/ld_split", ld_split32, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid32 = 1'b1; mem_rsp_data = 64'h0000_00CD;
    #1;
    check_val("postrst/ready", req_ready32, 64'd1);
    @(negedge clk);
    mem_rsp_valid32 = 1'b0;
    check_val("postrst/ld_valid", ld_valid32, 64'd0);
    check_val("postrst/rd_valid", mem_rd_valid32, 64'd0);
    check_val("postrst/ready2", req_ready32, 64'd1);
    do_load(1'b0, "after_rst", 32'h107, 3'd1, 64'hAB00_0000, 64'h0000_00CD, 64'hFFFF_CDAB, 1'b1, 32'h104, 32'h108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter WORD_SIZE, default 32, data width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  load request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_addr  input  ADDR_WIDTH  byte address of the load.
REQ-008 req_sel  input  3  access type: 0 BYTE, 1 HALF, 2 WORD, 3 UBYTE, 4 UHALF; 5 DWORD and 6 UWORD only when WORD_SIZE=64.
REQ-009 mem_rd_valid  output  1  memory read address valid.
REQ-010 mem_rd_ready  input  1  memory accepts the read address.
REQ-011 mem_rd_addr  output  ADDR_WIDTH  word-aligned read address; low log2(WORD_SIZE/8) bits are 0.
REQ-012 mem_rsp_valid  input  1  read data valid.
REQ-013 mem_rsp_data  input  WORD_SIZE  read data word.
REQ-014 ld_valid  output  1  one-cycle pulse; load result valid.
REQ-015 ld_data  output  WORD_SIZE  aligned, extended load result.
REQ-016 ld_split  output  1  qualified by ld_valid; 1 when the load used two memory reads.

Function
REQ-017 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE; req_ready=1 only in IDLE.
REQ-018 IDLE: on req_valid&&req_ready, register addr and sel, go to REQ0; otherwise stay.
REQ-019 REQ0: mem_rd_valid=1, mem_rd_addr=addr with offset bits cleared; go to WAIT0 on mem_rd_ready; address and valid stable while stalled.
REQ-020 WAIT0: on mem_rsp_valid, capture the low word; go to REQ1 if offset+size > WORD_SIZE/8, else DONE.
REQ-021 REQ1/WAIT1: same as REQ0/WAIT0 using aligned addr + WORD_SIZE/8, modulo 2^ADDR_WIDTH; the captured word is the high word; then DONE.
REQ-022 Access size in bytes: BYTE/UBYTE 1, HALF/UHALF 2, WORD/UWORD 4, DWORD 8.
REQ-023 DONE: ld_valid=1 for exactly one cycle, then IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-024 Alignment: form {high,low} (high=0 for single read), shift right by offset*8, take the low size bytes.
REQ-025 Extension: BYTE, HALF, and WORD at WORD_SIZE=64 sign-extend; UBYTE, UHALF, UWORD zero-extend; WORD at 32 and DWORD pass through.
REQ-026 Illegal req_sel (7; 5 or 6 at WORD_SIZE=32) is treated as size 1 with a single read, and ld_data=0.
REQ-027 mem_rsp_valid outside WAIT0/WAIT1 is ignored.
REQ-028 Minimum latency, acceptance to ld_valid, with mem_rd_ready=1 and the response one cycle after the address: aligned 4 cycles, split 6 cycles.
REQ-029 ld_data and ld_split hold their last value outside DONE.

Reset
REQ-030 rst asserted returns the FSM to IDLE immediately in any state, including mid-split.
REQ-031 While rst is asserted, ld_valid=0, mem_rd_valid=0, ld_data=0, ld_split=0, mem_rd_addr=0, and req_ready=0.
REQ-032 In the first cycle after rst deasserts, req_ready=1.
REQ-033 A response arriving after reset for a read issued before reset is ignored.

Verification
REQ-034 Aligned LW: addr 0x100, sel 2, mem word 0x8000_00F0 -> one read at 0x100; ld_data=0x8000_00F0; ld_split=0; latency 4 cycles.
REQ-035 LB/LBU: addr 0x103, mem 0x80FF_0000 -> LB gives 0xFFFF_FF80 and LBU gives 0x0000_0080, single read.
REQ-036 Split LH: addr 0x0000_0107, low word 0xAB00_0000, high word 0x0000_00CD -> reads at 0x104 then 0x108; ld_data=0xFFFF_CDAB; ld_split=1.
REQ-037 Wrap: addr 0xFFFF_FFFE, LW -> second read at 0x0000_0000; result is assembled from both words.
REQ-038 Stall and reset: mem_rd_ready=0 for 5 cycles, then the unit holds a stable address; rst is pulsed in WAIT1 with a late mem_rsp_valid -> the unit is IDLE with no ld_valid, and the next request completes normally.
REQ-039 WORD_SIZE=64: addr 0x0C, UWORD, mem 0x8000_0001_0000_0000 -> ld_data=0x0000_0000_8000_0001; ld_split=0.
